// File: rtl/user_entry_pkg.sv
// rtl/user_entry_pkg.sv - shared types and constants for the user code entry stage
package user_entry_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_READY,
    S_AUTH,
    S_ACTIVE,
    S_DROP
  } state_e;

  localparam int BITS_MAX   = 8;
  localparam int USER_W_DEF = BITS_MAX;

endpackage

// File: rtl/entry_timeout.sv
// rtl/entry_timeout.sv - inactivity counter; expired flags the edge that would reach TIMEOUT_CYCLES
module entry_timeout #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && count_q != LAST) begin
      count_d = count_q + CW'(1);
    end
  end

  // Flagged one count early so the caller changes state on the TIMEOUT_CYCLES-th edge.
  assign expired = enable && (count_q == LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/user_entry.sv
// rtl/user_entry.sv - serial user code entry and confirm sequencing in front of the access controller
module user_entry
  import user_entry_pkg::*;
#(
  parameter int USER_W         = USER_W_DEF,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              cancel,
  input  logic              bit_in,
  input  logic              bit_strobe,
  input  logic              enter,
  output logic              request,
  output logic              confirm,
  output logic [USER_W-1:0] user,
  output logic [3:0]        bit_count,
  output logic              active
);

  state_e            state_q, state_d;
  logic [USER_W-1:0] user_q, user_d;
  logic [3:0]        bit_count_q, bit_count_d;
  logic              confirm_q, confirm_d;
  logic              request_q, request_d;
  logic              active_q, active_d;
  logic              enter_q;
  logic              enter_rise;
  logic              accepted;
  logic              expired;
  logic              tmr_clear;
  logic              tmr_enable;

  // A held enter key counts once; it must drop before it can confirm again.
  assign enter_rise = enter && !enter_q;
  assign tmr_enable = (state_q == S_COLLECT) || (state_q == S_READY) || (state_q == S_AUTH);
  assign tmr_clear  = (state_d != state_q) || accepted;

  entry_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clock  (clock),
    .reset_n(reset_n),
    .clear  (tmr_clear),
    .enable (tmr_enable),
    .expired(expired)
  );

  always_comb begin
    state_d     = state_q;
    user_d      = user_q;
    bit_count_d = bit_count_q;
    confirm_d   = 1'b0;
    accepted    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          user_d      = '0;
          bit_count_d = '0;
          state_d     = S_COLLECT;
        end
      end
      S_DROP: state_d = S_IDLE;
      default: begin
        if (cancel || expired) begin
          state_d = S_DROP;
        end else if (state_q == S_COLLECT && bit_strobe) begin
          accepted    = 1'b1;
          user_d      = {user_q[USER_W-2:0], bit_in};
          bit_count_d = bit_count_q + 4'd1;
          if (bit_count_q == 4'(USER_W - 1)) begin
            state_d = S_READY;
          end
        end else if ((state_q == S_READY || state_q == S_AUTH) && enter_rise) begin
          accepted  = 1'b1;
          confirm_d = 1'b1;
          state_d   = (state_q == S_READY) ? S_AUTH : S_ACTIVE;
        end
      end
    endcase
    if (state_d == S_DROP) begin
      user_d      = '0;
      bit_count_d = '0;
    end
  end

  assign request_d = (state_d == S_COLLECT) || (state_d == S_READY) ||
                     (state_d == S_AUTH) || (state_d == S_ACTIVE);
  assign active_d  = (state_d == S_ACTIVE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      user_q      <= '0;
      bit_count_q <= '0;
      confirm_q   <= 1'b0;
      request_q   <= 1'b0;
      active_q    <= 1'b0;
      enter_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      user_q      <= user_d;
      bit_count_q <= bit_count_d;
      confirm_q   <= confirm_d;
      request_q   <= request_d;
      active_q    <= active_d;
      enter_q     <= enter;
    end
  end

  assign request   = request_q;
  assign confirm   = confirm_q;
  assign user      = user_q;
  assign bit_count = bit_count_q;
  assign active    = active_q;

endmodule
